// File: rtl/ctr_record_buffer.sv
// Control-transfer record capture: pairs each qualifying retired control transfer
// with the PC of the next retired instruction and keeps the records newest-first in a ring.
module ctr_record_buffer #(
    parameter int XLEN          = 64,
    parameter int NrCommitPorts = 2,
    parameter int Depth         = 16,
    parameter int TypeWidth     = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NrCommitPorts-1:0]           commit_valid_i,
    input  logic [NrCommitPorts*XLEN-1:0]      commit_pc_i,
    input  logic [NrCommitPorts*TypeWidth-1:0] commit_type_i,
    input  logic [NrCommitPorts*2-1:0]         commit_priv_i,
    input  logic [2**TypeWidth-1:0]            type_mask_i,
    input  logic [2:0]                         priv_en_i,
    input  logic                               freeze_i,
    input  logic                               clear_i,
    input  logic [$clog2(Depth)-1:0]           rd_idx_i,
    output logic [XLEN-1:0]                    rd_source_o,
    output logic [XLEN-1:0]                    rd_target_o,
    output logic [TypeWidth-1:0]               rd_type_o,
    output logic [1:0]                         rd_priv_o,
    output logic [$clog2(Depth):0]             count_o,
    output logic [$clog2(NrCommitPorts):0]     record_o
);

    localparam int IdxW  = $clog2(Depth);
    localparam int CntW  = IdxW + 1;
    localparam int CntW1 = CntW + 1;
    localparam int RecW  = $clog2(NrCommitPorts) + 1;

    function automatic logic priv_enabled(input logic [1:0] priv, input logic [2:0] en);
        case (priv)
            2'd0:    return en[0];
            2'd1:    return en[1];
            2'd3:    return en[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic qualifies(input logic [TypeWidth-1:0] cftype,
                                       input logic [1:0] priv,
                                       input logic [2**TypeWidth-1:0] mask,
                                       input logic [2:0] en);
        return (cftype != '0) && mask[cftype] && priv_enabled(priv, en);
    endfunction

    function automatic logic [CntW-1:0] sat_count(input logic [CntW-1:0] cnt,
                                                  input logic [RecW-1:0] n);
        logic [CntW1-1:0] sum;
        sum = {1'b0, cnt} + CntW1'(n);
        if (sum > CntW1'(Depth)) return CntW'(Depth);
        return sum[CntW-1:0];
    endfunction

    // Registered pending source and ring state
    logic                 pend_vld_p1;
    logic [XLEN-2:0]      pend_pc_p1;
    logic [TypeWidth-1:0] pend_type_p1;
    logic [1:0]           pend_priv_p1;
    logic [IdxW-1:0]      wptr_p1;
    logic [CntW-1:0]      count_p1;
    logic [Depth-1:0]     slot_vld_p1;
    logic [XLEN-2:0]      src_mem  [Depth];
    logic [XLEN-2:0]      tgt_mem  [Depth];
    logic [TypeWidth-1:0] type_mem [Depth];
    logic [1:0]           priv_mem [Depth];

    logic                 chain_vld;
    logic [XLEN-2:0]      chain_pc;
    logic [TypeWidth-1:0] chain_type;
    logic [1:0]           chain_priv;
    logic [XLEN-1:0]      port_pc;
    logic [TypeWidth-1:0] port_type;
    logic [1:0]           port_priv;
    logic [RecW-1:0]      n_rec;
    logic                 rec_en   [NrCommitPorts];
    logic [RecW-1:0]      rec_off  [NrCommitPorts];
    logic [IdxW-1:0]      wr_slot  [NrCommitPorts];
    logic [XLEN-2:0]      rec_src  [NrCommitPorts];
    logic [XLEN-2:0]      rec_tgt  [NrCommitPorts];
    logic [TypeWidth-1:0] rec_type [NrCommitPorts];
    logic [1:0]           rec_priv [NrCommitPorts];
    logic [NrCommitPorts-1:0] unused_pc_lsb;

    // Stage p0: in-order commit chain seeded by the registered pending source
    always_comb begin
        chain_vld  = pend_vld_p1;
        chain_pc   = pend_pc_p1;
        chain_type = pend_type_p1;
        chain_priv = pend_priv_p1;
        port_pc    = '0;
        port_type  = '0;
        port_priv  = '0;
        n_rec      = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            port_pc          = commit_pc_i[p*XLEN +: XLEN];
            port_type        = commit_type_i[p*TypeWidth +: TypeWidth];
            port_priv        = commit_priv_i[p*2 +: 2];
            unused_pc_lsb[p] = port_pc[0];
            rec_en[p]        = 1'b0;
            rec_off[p]       = n_rec;
            wr_slot[p]       = wptr_p1 + IdxW'(n_rec);
            rec_src[p]       = chain_pc;
            rec_tgt[p]       = port_pc[XLEN-1:1];
            rec_type[p]      = chain_type;
            rec_priv[p]      = chain_priv;
            if (commit_valid_i[p] && !freeze_i) begin
                if (chain_vld) begin
                    rec_en[p] = 1'b1;
                    n_rec     = n_rec + RecW'(1);
                end
                chain_vld  = qualifies(port_type, port_priv, type_mask_i, priv_en_i);
                chain_pc   = port_pc[XLEN-1:1];
                chain_type = port_type;
                chain_priv = port_priv;
            end
        end
    end

    // Stage p1: control state, clear beats freeze and recording
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_vld_p1 <= 1'b0;
            wptr_p1     <= '0;
            count_p1    <= '0;
            record_o    <= '0;
            slot_vld_p1 <= '0;
        end else if (clear_i) begin
            pend_vld_p1 <= 1'b0;
            wptr_p1     <= '0;
            count_p1    <= '0;
            record_o    <= '0;
            slot_vld_p1 <= '0;
        end else begin
            pend_vld_p1 <= chain_vld && !freeze_i;
            wptr_p1     <= wptr_p1 + IdxW'(n_rec);
            count_p1    <= sat_count(count_p1, n_rec);
            record_o    <= n_rec;
            for (int p = 0; p < NrCommitPorts; p++) begin
                if (rec_en[p]) slot_vld_p1[wr_slot[p]] <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; visibility is governed by the valid bits and count
    always_ff @(posedge clk_i) begin
        pend_pc_p1   <= chain_pc;
        pend_type_p1 <= chain_type;
        pend_priv_p1 <= chain_priv;
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (rec_en[p]) begin
                src_mem[wr_slot[p]]  <= rec_src[p];
                tgt_mem[wr_slot[p]]  <= rec_tgt[p];
                type_mem[wr_slot[p]] <= rec_type[p];
                priv_mem[wr_slot[p]] <= rec_priv[p];
            end
        end
    end

    logic [IdxW-1:0] rd_slot;
    logic            rd_hit;

    // Combinational read: logical index 0 is the slot just below the write pointer
    always_comb begin
        rd_slot     = wptr_p1 - IdxW'(1) - rd_idx_i;
        rd_hit      = ({1'b0, rd_idx_i} < count_p1) && slot_vld_p1[rd_slot];
        rd_source_o = '0;
        rd_target_o = '0;
        rd_type_o   = '0;
        rd_priv_o   = '0;
        if (rd_hit) begin
            rd_source_o = {src_mem[rd_slot], 1'b1};
            rd_target_o = {tgt_mem[rd_slot], 1'b0};
            rd_type_o   = type_mem[rd_slot];
            rd_priv_o   = priv_mem[rd_slot];
        end
    end

    assign count_o = count_p1;

endmodule

// File: tb/tb_ctr_record_buffer.sv
// Scoreboard bench for ctr_record_buffer (2 commit ports, 4-entry ring).
module tb_ctr_record_buffer;

    localparam int XLEN = 64;
    localparam int NP   = 2;
    localparam int DEP  = 4;
    localparam int TW   = 4;

    typedef struct {
        logic [63:0] src;
        logic [63:0] tgt;
        logic [3:0]  typ;
        logic [1:0]  prv;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP-1:0]        cv;
    logic [NP*XLEN-1:0]   cpc;
    logic [NP*TW-1:0]     ctype;
    logic [NP*2-1:0]      cpriv;
    logic [15:0]          tmask;
    logic [2:0]           pen;
    logic                 freeze;
    logic                 clr;
    logic [1:0]           rd_idx;
    logic [XLEN-1:0]      rd_source;
    logic [XLEN-1:0]      rd_target;
    logic [TW-1:0]        rd_type;
    logic [1:0]           rd_priv;
    logic [2:0]           count;
    logic [1:0]           record;

    int   checks    = 0;
    int   failures  = 0;
    int   exp_count = 0;
    rec_t exp_q[$];

    ctr_record_buffer #(.XLEN(XLEN), .NrCommitPorts(NP), .Depth(DEP), .TypeWidth(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .commit_valid_i(cv), .commit_pc_i(cpc), .commit_type_i(ctype), .commit_priv_i(cpriv),
        .type_mask_i(tmask), .priv_en_i(pen), .freeze_i(freeze), .clear_i(clr),
        .rd_idx_i(rd_idx), .rd_source_o(rd_source), .rd_target_o(rd_target),
        .rd_type_o(rd_type), .rd_priv_o(rd_priv), .count_o(count), .record_o(record)
    );

    always #5 clk = ~clk;

    task automatic set_port(input int p, input logic v, input logic [63:0] pc,
                            input logic [3:0] t, input logic [1:0] pr);
        cv[p]            = v;
        cpc[p*XLEN +: XLEN] = pc;
        ctype[p*TW +: TW]   = t;
        cpriv[p*2 +: 2]     = pr;
    endtask

    task automatic idle_ports();
        cv = '0; cpc = '0; ctype = '0; cpriv = '0;
    endtask

    // Advance one clock and drain the scoreboard for that cycle (newest first).
    task automatic step_and_score(input string nm);
        int   n;
        rec_t e;
        @(posedge clk); #1;
        n = exp_q.size();
        exp_count = (exp_count + n > DEP) ? DEP : exp_count + n;
        checks++;
        if (record !== 2'(n)) begin
            failures++;
            $display("FAIL %s record_o got=%0d exp=%0d", nm, record, n);
        end
        checks++;
        if (count !== 3'(exp_count)) begin
            failures++;
            $display("FAIL %s count_o got=%0d exp=%0d", nm, count, exp_count);
        end
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_back();
            rd_idx = 2'(k);
            #1;
            checks++;
            if (rd_source !== {e.src[63:1], 1'b1} || rd_target !== {e.tgt[63:1], 1'b0} ||
                rd_type !== e.typ || rd_priv !== e.prv) begin
                failures++;
                $display("FAIL %s idx%0d got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d", nm, k,
                         rd_source, rd_target, rd_type, rd_priv,
                         {e.src[63:1], 1'b1}, {e.tgt[63:1], 1'b0}, e.typ, e.prv);
            end
        end
        rd_idx = 2'd0;
    endtask

    task automatic do_clear(input string nm);
        idle_ports();
        clr = 1'b1;
        exp_q.delete();
        exp_count = 0;
        step_and_score(nm);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_ports();
        tmask = 16'hFFFF; pen = 3'b111; freeze = 1'b0; clr = 1'b0; rd_idx = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0 || record !== 2'd0) begin
            failures++;
            $display("FAIL reset count/record got=%0d/%0d exp=0/0", count, record);
        end
        checks++;
        if (rd_source !== '0 || rd_target !== '0 || rd_type !== '0 || rd_priv !== '0) begin
            failures++;
            $display("FAIL reset rd got=%h/%h exp=0/0", rd_source, rd_target);
        end
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_single();
        set_port(0, 1'b1, 64'h1000, 4'd4, 2'd3);
        step_and_score("single_c1");
        idle_ports();
        step_and_score("single_c2");
        set_port(0, 1'b1, 64'h2000, 4'd0, 2'd3);
        exp_q.push_back('{64'h1000, 64'h2000, 4'd4, 2'd3});
        step_and_score("single_c3");
        idle_ports();
    endtask

    task automatic test_dual();
        set_port(0, 1'b1, 64'h1000, 4'd4, 2'd3);
        step_and_score("dual_c1");
        set_port(0, 1'b1, 64'h2000, 4'd5, 2'd3);
        set_port(1, 1'b1, 64'h3000, 4'd0, 2'd3);
        exp_q.push_back('{64'h1000, 64'h2000, 4'd4, 2'd3});
        exp_q.push_back('{64'h2000, 64'h3000, 4'd5, 2'd3});
        step_and_score("dual_c2");
        idle_ports();
    endtask

    task automatic test_filter();
        do_clear("filter_clear");
        tmask = 16'hFFEF;
        set_port(0, 1'b1, 64'h1000, 4'd4, 2'd3);
        step_and_score("filter_type_a");
        set_port(0, 1'b1, 64'h2000, 4'd0, 2'd3);
        step_and_score("filter_type_b");
        tmask = 16'hFFFF; pen = 3'b001;
        set_port(0, 1'b1, 64'h1000, 4'd4, 2'd1);
        step_and_score("filter_priv_a");
        set_port(0, 1'b1, 64'h2000, 4'd0, 2'd1);
        step_and_score("filter_priv_b");
        pen = 3'b111;
        idle_ports();
    endtask

    task automatic test_wrap();
        do_clear("wrap_clear");
        for (int i = 1; i <= 7; i++) begin
            set_port(0, 1'b1, 64'(i * 'h100), (i == 7) ? 4'd0 : 4'd4, 2'd3);
            if (i >= 2) exp_q.push_back('{64'((i - 1) * 'h100), 64'(i * 'h100), 4'd4, 2'd3});
            step_and_score("wrap_step");
            if (i == 2) begin
                rd_idx = 2'd1; #1;
                checks++;
                if (rd_source !== '0 || rd_target !== '0 || rd_type !== '0 || rd_priv !== '0) begin
                    failures++;
                    $display("FAIL wrap_beyond_count got=%h/%h/%0d exp=0/0/0", rd_source, rd_target, rd_type);
                end
                rd_idx = 2'd0;
            end
        end
        idle_ports();
        rd_idx = 2'd3; #1;
        checks++;
        if (rd_source !== 64'h301) begin
            failures++;
            $display("FAIL wrap_idx3_source got=%h exp=%h", rd_source, 64'h301);
        end
        rd_idx = 2'd0; #1;
        checks++;
        if (rd_target !== 64'h700) begin
            failures++;
            $display("FAIL wrap_idx0_target got=%h exp=%h", rd_target, 64'h700);
        end
    endtask

    task automatic test_back_to_back();
        do_clear("b2b_clear");
        set_port(0, 1'b1, 64'hA00, 4'd4, 2'd3);
        set_port(1, 1'b1, 64'hB00, 4'd6, 2'd1);
        exp_q.push_back('{64'hA00, 64'hB00, 4'd4, 2'd3});
        step_and_score("b2b_c1");
        set_port(0, 1'b1, 64'hC00, 4'd5, 2'd3);
        set_port(1, 1'b1, 64'hD00, 4'd4, 2'd0);
        exp_q.push_back('{64'hB00, 64'hC00, 4'd6, 2'd1});
        exp_q.push_back('{64'hC00, 64'hD00, 4'd5, 2'd3});
        step_and_score("b2b_c2");
        set_port(0, 1'b0, 64'h5550, 4'd4, 2'd3);
        set_port(1, 1'b1, 64'hE01, 4'd0, 2'd3);
        exp_q.push_back('{64'hD00, 64'hE01, 4'd4, 2'd0});
        step_and_score("b2b_c3_skip_port0");
        idle_ports();
    endtask

    task automatic test_freeze_clear();
        do_clear("frz_clear");
        set_port(0, 1'b1, 64'h1000, 4'd4, 2'd3);
        step_and_score("frz_pend");
        set_port(0, 1'b1, 64'h1100, 4'd4, 2'd3);
        exp_q.push_back('{64'h1000, 64'h1100, 4'd4, 2'd3});
        step_and_score("frz_rec");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1'b1, 64'(64'h2000 + i * 'h1000), 4'd4, 2'd3);
            step_and_score("frz_hold");
        end
        checks++;
        if (rd_source !== 64'h1001) begin
            failures++;
            $display("FAIL frz_readable got=%h exp=%h", rd_source, 64'h1001);
        end
        freeze = 1'b0;
        set_port(0, 1'b1, 64'h5000, 4'd4, 2'd3);
        step_and_score("frz_release_no_complete");
        set_port(0, 1'b1, 64'h6000, 4'd0, 2'd3);
        clr = 1'b1;
        exp_count = 0;
        step_and_score("clr_drop");
        clr = 1'b0;
        set_port(0, 1'b1, 64'h7000, 4'd0, 2'd3);
        step_and_score("clr_pend_dropped");
        idle_ports();
    endtask

    task automatic test_async_reset();
        set_port(0, 1'b1, 64'h100, 4'd4, 2'd3);
        step_and_score("arst_pend");
        set_port(0, 1'b1, 64'h200, 4'd4, 2'd3);
        exp_q.push_back('{64'h100, 64'h200, 4'd4, 2'd3});
        step_and_score("arst_rec");
        idle_ports();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || record !== 2'd0) begin
            failures++;
            $display("FAIL arst_count got=%0d/%0d exp=0/0", count, record);
        end
        checks++;
        if (rd_source !== '0 || rd_target !== '0 || rd_type !== '0 || rd_priv !== '0) begin
            failures++;
            $display("FAIL arst_rd got=%h/%h/%0d/%0d exp=0", rd_source, rd_target, rd_type, rd_priv);
        end
        #2 rst = 1'b0;
        exp_count = 0;
        set_port(0, 1'b1, 64'h300, 4'd0, 2'd3);
        step_and_score("arst_first_commit");
        idle_ports();
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_filter();
        test_wrap();
        test_back_to_back();
        test_freeze_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
